// File: rtl/fifo_rr_reader_pkg.sv
// fifo_if_pkg: shared constants for the d0/d1 round-robin FIFO reader.
// Holds the default word width, the channel encodings used for the
// pop grant and the output tag, and the output buffer depth.
package fifo_if_pkg;
  localparam int   DEF_DATA_SIZE = 6;
  localparam int   DEF_CNT_SIZE  = 8;
  localparam logic CH_D0         = 1'b0;
  localparam logic CH_D1         = 1'b1;
  localparam int   BUF_DEPTH     = 2;
endpackage

// File: rtl/fifo_rr_reader_if.sv
// fifo_rr_reader_if: downstream valid/ready stream carrying a tagged word.
//   data  : word at the head of the reader's output buffer
//   dest  : source channel of that word (CH_D0 / CH_D1)
//   valid : head word present
//   ready : consumer accepts; a transfer happens when valid && ready
// master = producer (fifo_rr_reader), slave = consumer.
interface fifo_rr_reader_if #(
  parameter int DATA_SIZE = 6
);
  logic [DATA_SIZE-1:0] data;
  logic                 dest;
  logic                 valid;
  logic                 ready;

  modport master (output data, output dest, output valid, input ready);
  modport slave  (input data, input dest, input valid, output ready);
endinterface

// File: rtl/fifo_rr_reader_rr_out_buf.sv
// rr_out_buf: 2-entry FIFO of words tagged with their source channel.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : write i_push_data / i_push_tag at the tail
//   i_pop         : retire the head entry (ignored when empty)
//   o_occ         : occupancy, 0..2
//   o_head_data   : head word
//   o_head_tag    : head channel tag
// A push into a full buffer is accepted only when the head retires in the
// same cycle; the reader's credit logic guarantees it never needs more.
module rr_out_buf
  import fifo_if_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [DATA_SIZE-1:0] i_push_data,
  input  logic                 i_push_tag,
  input  logic                 i_pop,
  output logic [1:0]           o_occ,
  output logic [DATA_SIZE-1:0] o_head_data,
  output logic                 o_head_tag
);

  logic [1:0][DATA_SIZE-1:0] r_data;
  logic [1:0]                r_tag;
  logic                      r_rd_ptr;
  logic                      r_wr_ptr;
  logic [1:0]                r_occ;
  logic                      w_push;
  logic                      w_pop;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'(BUF_DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_tag    <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_tag[r_wr_ptr]  <= i_push_tag;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_tag  = r_tag[r_rd_ptr];

  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_occ <= 2'(BUF_DEPTH));

endmodule

// File: rtl/fifo_rr_reader.sv
// fifo_rr_reader: read-side controller for the d0/d1 FIFO pair.
// Pops the two FIFOs round-robin (never an empty one), captures the word
// returned one cycle after each pop into a 2-entry tagged buffer, and
// presents the buffer head downstream on a valid/ready stream.
// Ports:
//   clk, reset_L            : clock, asynchronous active-low reset
//   enable                  : allow new pops (in-flight words still land)
//   fifo_empty_d0/d1        : FIFO empty flags
//   data_in_d0/d1           : FIFO read data, valid the cycle after a pop
//   pop_d0/pop_d1           : combinational pop requests
//   idle_out                : nothing in flight and buffer empty
//   cnt_d0/cnt_d1           : wrapping count of words delivered per source
//   out_if (master)         : data/dest/valid out, ready in
module fifo_rr_reader
  import fifo_if_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int CNT_SIZE  = DEF_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic                 fifo_empty_d0,
  input  logic                 fifo_empty_d1,
  input  logic [DATA_SIZE-1:0] data_in_d0,
  input  logic [DATA_SIZE-1:0] data_in_d1,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic                 idle_out,
  output logic [CNT_SIZE-1:0]  cnt_d0,
  output logic [CNT_SIZE-1:0]  cnt_d1,
  fifo_rr_reader_if.master     out_if
);

  logic                 r_inflight_p1;
  logic                 r_inflight_ch_p1;
  logic                 r_last_grant;
  logic [CNT_SIZE-1:0]  r_cnt_d0;
  logic [CNT_SIZE-1:0]  r_cnt_d1;

  logic [1:0]           w_occ;
  logic [DATA_SIZE-1:0] w_head_data;
  logic                 w_head_tag;
  logic                 w_drain;
  logic                 w_req0;
  logic                 w_req1;
  logic                 w_grant;
  logic [2:0]           w_load;
  logic [2:0]           w_limit;
  logic                 w_pop;
  logic [DATA_SIZE-1:0] w_cap_data;

  assign w_drain = (w_occ != 2'd0) && out_if.ready;
  assign w_req0  = !fifo_empty_d0;
  assign w_req1  = !fifo_empty_d1;

  // Stage p0: arbitration and credit check. Buffer slots already committed
  // (occupied + word in flight) must stay below the depth once this cycle's
  // drain is credited back. Gating with reset_L drops pops the instant
  // reset asserts rather than at the next edge.
  always_comb begin
    w_grant = CH_D0;
    if (w_req0 && w_req1) begin
      w_grant = ~r_last_grant;
    end else if (w_req1) begin
      w_grant = CH_D1;
    end
    w_load  = {1'b0, w_occ} + {2'b00, r_inflight_p1};
    w_limit = 3'(BUF_DEPTH) + {2'b00, w_drain};
    w_pop   = reset_L && enable && (w_req0 || w_req1) && (w_load < w_limit);
  end

  assign pop_d0 = w_pop && (w_grant == CH_D0);
  assign pop_d1 = w_pop && (w_grant == CH_D1);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_inflight_p1    <= 1'b0;
      r_inflight_ch_p1 <= CH_D0;
      r_last_grant     <= CH_D1;
      r_cnt_d0         <= '0;
      r_cnt_d1         <= '0;
    end else begin
      r_inflight_p1 <= w_pop;
      if (w_pop) begin
        r_inflight_ch_p1 <= w_grant;
        r_last_grant     <= w_grant;
      end
      if (w_drain) begin
        if (w_head_tag == CH_D1) begin
          r_cnt_d1 <= r_cnt_d1 + 1'b1;
        end else begin
          r_cnt_d0 <= r_cnt_d0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: FIFO read data for last cycle's pop is captured into the buffer.
  assign w_cap_data = (r_inflight_ch_p1 == CH_D1) ? data_in_d1 : data_in_d0;

  rr_out_buf #(
    .DATA_SIZE(DATA_SIZE)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (reset_L),
    .i_push      (r_inflight_p1),
    .i_push_data (w_cap_data),
    .i_push_tag  (r_inflight_ch_p1),
    .i_pop       (w_drain),
    .o_occ       (w_occ),
    .o_head_data (w_head_data),
    .o_head_tag  (w_head_tag)
  );

  // Stage p2: buffer head presented downstream.
  assign out_if.data  = w_head_data;
  assign out_if.dest  = w_head_tag;
  assign out_if.valid = (w_occ != 2'd0);
  assign idle_out     = (w_occ == 2'd0) && !r_inflight_p1;
  assign cnt_d0       = r_cnt_d0;
  assign cnt_d1       = r_cnt_d1;

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Testbench for fifo_rr_reader: behavioural d0/d1 FIFOs, a scoreboard of
// expected (data, dest) pairs filled by the stimulus, and a monitor that
// checks every accepted transfer against it.
module tb_fifo_rr_reader;
  import fifo_if_pkg::*;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk           = 1'b0;
  logic          reset_L       = 1'b0;
  logic          enable        = 1'b0;
  logic          fifo_empty_d0 = 1'b1;
  logic          fifo_empty_d1 = 1'b1;
  logic [DW-1:0] data_in_d0    = '0;
  logic [DW-1:0] data_in_d1    = '0;
  logic          pop_d0;
  logic          pop_d1;
  logic          idle_out;
  logic [CW-1:0] cnt_d0;
  logic [CW-1:0] cnt_d1;

  fifo_rr_reader_if #(.DATA_SIZE(DW)) out_if ();

  fifo_rr_reader #(
    .DATA_SIZE(DW),
    .CNT_SIZE (CW)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .fifo_empty_d0 (fifo_empty_d0),
    .fifo_empty_d1 (fifo_empty_d1),
    .data_in_d0    (data_in_d0),
    .data_in_d1    (data_in_d1),
    .pop_d0        (pop_d0),
    .pop_d1        (pop_d1),
    .idle_out      (idle_out),
    .cnt_d0        (cnt_d0),
    .cnt_d1        (cnt_d1),
    .out_if        (out_if)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   sb[$];
  logic          m_p0;
  logic          m_p1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic ch);
    sb.push_back({ch, d});
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    step(1);
    while (!(idle_out && q0.size() == 0 && q1.size() == 0 && sb.size() == 0) && k < 2000) begin
      step(1);
      k++;
    end
    chk({nm, "_drain_in_time"}, int'(k < 2000), 1);
  endtask

  // FIFO model: a pop seen at an edge returns its word 1 unit later and
  // holds it until the next pop; empty flags follow the queue contents.
  always @(posedge clk) begin
    m_p0 = pop_d0;
    m_p1 = pop_d1;
    #1;
    if (m_p0) begin
      chk("pop_d0_nonempty", int'(q0.size() != 0), 1);
      if (q0.size() != 0) data_in_d0 = q0.pop_front();
    end
    if (m_p1) begin
      chk("pop_d1_nonempty", int'(q1.size() != 0), 1);
      if (q1.size() != 0) data_in_d1 = q1.pop_front();
    end
    fifo_empty_d0 = (q0.size() == 0);
    fifo_empty_d1 = (q1.size() == 0);
  end

  // Monitor: every accepted transfer must match the scoreboard head.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset_L && out_if.valid && out_if.ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", int'(out_if.data), -1);
      end else begin
        e = sb.pop_front();
        chk("sb_data", int'(out_if.data), int'(e[DW-1:0]));
        chk("sb_dest", int'(out_if.dest), int'(e[DW]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    out_if.ready = 1'b0;
    step(2);

    // Reset state
    chk("rst_valid", int'(out_if.valid), 0);
    chk("rst_idle",  int'(idle_out), 1);
    chk("rst_data",  int'(out_if.data), 0);
    chk("rst_dest",  int'(out_if.dest), 0);
    chk("rst_cnt0",  int'(cnt_d0), 0);
    chk("rst_cnt1",  int'(cnt_d1), 0);
    chk("rst_pop0",  int'(pop_d0), 0);
    chk("rst_pop1",  int'(pop_d1), 0);
    reset_L      = 1'b1;
    enable       = 1'b1;
    out_if.ready = 1'b1;
    step(1);

    // A: interleaved stream, full rate
    q0.push_back(6'h0A); q0.push_back(6'h0B);
    q1.push_back(6'h15); q1.push_back(6'h16);
    push_exp(6'h0A, CH_D0); push_exp(6'h15, CH_D1);
    push_exp(6'h0B, CH_D0); push_exp(6'h16, CH_D1);
    step(1);
    chk("A_t0_pop0", int'(pop_d0), 1);
    chk("A_t0_pop1", int'(pop_d1), 0);
    step(1);
    chk("A_t1_valid", int'(out_if.valid), 0);
    chk("A_t1_pop1",  int'(pop_d1), 1);
    step(1);
    chk("A_t2_valid", int'(out_if.valid), 1);
    chk("A_t2_data",  int'(out_if.data), 'h0A);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("A_b2b_valid", int'(out_if.valid), 1);
    end
    step(1);
    chk("A_end_valid", int'(out_if.valid), 0);
    chk("A_end_idle",  int'(idle_out), 1);
    chk("A_cnt0", int'(cnt_d0), 2);
    chk("A_cnt1", int'(cnt_d1), 2);

    // B: only d1, stalled consumer
    out_if.ready = 1'b0;
    q1.push_back(6'h21); q1.push_back(6'h22); q1.push_back(6'h23);
    push_exp(6'h21, CH_D1); push_exp(6'h22, CH_D1); push_exp(6'h23, CH_D1);
    step(1);
    chk("B_t0_pop1", int'(pop_d1), 1);
    step(1);
    chk("B_t1_pop1", int'(pop_d1), 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("B_stall_pop0", int'(pop_d0), 0);
      chk("B_stall_pop1", int'(pop_d1), 0);
      chk("B_stall_valid", int'(out_if.valid), 1);
      chk("B_stall_data", int'(out_if.data), 'h21);
      chk("B_stall_dest", int'(out_if.dest), 1);
    end
    chk("B_q1_left", q1.size(), 1);
    out_if.ready = 1'b1;
    wait_idle("B");
    chk("B_cnt0", int'(cnt_d0), 2);
    chk("B_cnt1", int'(cnt_d1), 5);

    // C: enable drops the cycle after a pop
    q0.push_back(6'h2A); q0.push_back(6'h2C);
    push_exp(6'h2A, CH_D0);
    step(1);
    chk("C_t0_pop0", int'(pop_d0), 1);
    step(1);
    enable = 1'b0;
    #1;
    chk("C_t1_pop0", int'(pop_d0), 0);
    chk("C_t1_pop1", int'(pop_d1), 0);
    step(1);
    chk("C_t2_valid", int'(out_if.valid), 1);
    chk("C_t2_data",  int'(out_if.data), 'h2A);
    chk("C_t2_pop0",  int'(pop_d0), 0);
    step(1);
    chk("C_t3_idle",  int'(idle_out), 1);
    chk("C_t3_valid", int'(out_if.valid), 0);
    chk("C_t3_pop0",  int'(pop_d0), 0);
    chk("C_q0_left",  q0.size(), 1);
    enable = 1'b1;
    push_exp(6'h2C, CH_D0);
    wait_idle("C");
    chk("C_cnt0", int'(cnt_d0), 4);

    // D: both FIFOs empty
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("D_pop0",  int'(pop_d0), 0);
      chk("D_pop1",  int'(pop_d1), 0);
      chk("D_valid", int'(out_if.valid), 0);
    end

    // E: reset mid-stream, then d0 must win first
    out_if.ready = 1'b0;
    q0.push_back(6'h30); q0.push_back(6'h31); q0.push_back(6'h32); q0.push_back(6'h33);
    step(1);
    step(1);
    chk("E_pre_pop0", int'(pop_d0), 1);
    reset_L = 1'b0;
    #1;
    chk("E_rst_pop0",  int'(pop_d0), 0);
    chk("E_rst_pop1",  int'(pop_d1), 0);
    chk("E_rst_valid", int'(out_if.valid), 0);
    chk("E_rst_idle",  int'(idle_out), 1);
    chk("E_rst_cnt0",  int'(cnt_d0), 0);
    chk("E_rst_cnt1",  int'(cnt_d1), 0);
    sb.delete();
    q1.push_back(6'h39);
    step(1);
    reset_L = 1'b1;
    #1;
    chk("E_first_pop0", int'(pop_d0), 1);
    chk("E_first_pop1", int'(pop_d1), 0);
    push_exp(6'h31, CH_D0); push_exp(6'h39, CH_D1);
    push_exp(6'h32, CH_D0); push_exp(6'h33, CH_D0);
    out_if.ready = 1'b1;
    wait_idle("E");
    chk("E_cnt0", int'(cnt_d0), 3);
    chk("E_cnt1", int'(cnt_d1), 1);

    // F: d0 counter wrap after 256 words since reset
    for (int i = 0; i < 252; i++) begin
      q0.push_back(DW'(i));
      push_exp(DW'(i), CH_D0);
    end
    wait_idle("F1");
    chk("F_cnt0_255", int'(cnt_d0), 255);
    q0.push_back(6'h3F);
    push_exp(6'h3F, CH_D0);
    wait_idle("F2");
    chk("F_cnt0_wrap", int'(cnt_d0), 0);
    chk("F_cnt1_hold", int'(cnt_d1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
